transmissor_estado_drone: RTL
=============================

Name: transmissor_estado_drone

Overview:
Serial transmitter for the drone simulator's game state, carrying state game→player (the opposite direction to the player→game control inputs). On a request it snapshots the drone position, obstacle pattern, mode, lives and win/lose flags. It then sends them as a fixed 5-byte UART 8N1 frame to a PC or display board. It sits beside the simulator top and consumes its debug/status outputs.

Parameters:
CICLOS_POR_BIT, 5208, clock cycles per serial bit (50 MHz / 9600 baud); must be >= 2.

Ports:
clock  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
enviar  input  1  level request; sampled only in INICIAL state
posicao_horizontal  input  4  drone horizontal position
posicao_vertical  input  4  drone vertical position
obstaculos  input  4  current obstacle pattern
modo  input  2  selected game mode
vidas  input  3  remaining lives / collision counter
venceu  input  1  win flag
perdeu  input  1  lose flag
saida_serial  output  1  UART TX line, idle high, registered
ocupado  output  1  high from accepted request until frame end
pronto  output  1  one-cycle pulse at frame end
db_estado  output  4  current FSM state code

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values:
  - saida_serial=1, ocupado=0, pronto=0, db_estado=INICIAL (0x0).
  - Bit counter, byte index and baud counter cleared.
  - Snapshot registers cleared.
- Frame (byte order 0..4), each byte sent LSB first as start(0), 8 data bits, stop(1):
  - B0 = 0xA5 header.
  - B1 = {posicao_horizontal, posicao_vertical}.
  - B2 = {obstaculos, modo, venceu, perdeu}.
  - B3 = {5'b00000, vidas}.
  - B4 = B1 ^ B2 ^ B3 checksum.
- Snapshot:
  - All status inputs are registered on the edge where enviar=1 is accepted.
  - Input changes during the frame do not affect it.
- FSM states and codes:
  - INICIAL 0x0: line high; enviar=1 -> START at the next edge, with snapshot captured, byte index=0 and ocupado=1.
  - START 0x1: line low for CICLOS_POR_BIT cycles -> DADOS.
  - DADOS 0x2: line = current data bit; 8 bits of CICLOS_POR_BIT cycles each -> STOP.
  - STOP 0x3: line high for CICLOS_POR_BIT cycles. Then byte index<4 -> PROXIMO; byte index=4 -> FIM.
  - PROXIMO 0x4: zero-duration bookkeeping folded into the STOP exit edge: increment byte index, load next byte -> START. There is no idle gap between bytes.
  - FIM 0x5: one cycle; pronto=1, ocupado=0, line high -> INICIAL.
- Timing:
  - saida_serial changes on the same edge as the state entering START.
  - The first start bit is low during the cycle after acceptance.
  - Request-accept to pronto pulse is exactly 50*CICLOS_POR_BIT+1 cycles.
- Baud counter:
  - Counts 0..CICLOS_POR_BIT-1 and is reset on every bit boundary.
  - Width is ceil(log2(CICLOS_POR_BIT)).
- enviar while ocupado=1 is ignored; it is not queued.
- enviar held high continuously: a new frame starts on the edge after FIM. Frames are back-to-back with no idle bit.
- reset mid-frame: on the next edge saida_serial=1 and state=INICIAL; the partial frame is abandoned and no pronto pulse is produced.
- reset and enviar in the same cycle: reset wins.
- Unused state codes return to INICIAL with line high.

Test Plan:
- Reset for 2 cycles, then idle with CICLOS_POR_BIT=4 -> saida_serial=1, ocupado=0, pronto=0, db_estado=0 held indefinitely.
- Inputs posicao_horizontal=3, posicao_vertical=7, obstaculos=0xA, modo=2, venceu=0, perdeu=1, vidas=3; pulse enviar, sampling the line mid-bit -> bytes A5, 37, A9, 03, 9D, each with start=0 and stop=1. pronto pulses exactly 201 cycles after the accept edge.
- Same frame in flight; change all status inputs and pulse enviar at byte 2 -> transmitted bytes unchanged, no second frame, pronto pulses once.
- enviar held high for 500 cycles -> consecutive identical frames with no idle gap. Each B0 start bit follows the prior B4 stop bit, with exactly 1 FIM cycle between frames.
- reset asserted during DADOS of B2 -> saida_serial=1 and db_estado=0 on the next edge, no pronto pulse. A new enviar then sends a complete frame from B0.
- All status inputs zero plus venceu=1 -> B1=0x00, B2=0x02, B3=0x00, checksum 0x02.

Source files
------------

// File: rtl/transmissor_estado_drone.sv
`default_nettype none
// ============================================================================
// Module  : transmissor_estado_drone
// Brief   : UART 8N1 transmitter sending a 5-byte drone game-state frame.
// Revision: 1.0 - initial release
// ============================================================================
module transmissor_estado_drone #(
    parameter int CICLOS_POR_BIT = 5208
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enviar,
    input  logic [3:0] posicao_horizontal,
    input  logic [3:0] posicao_vertical,
    input  logic [3:0] obstaculos,
    input  logic [1:0] modo,
    input  logic [2:0] vidas,
    input  logic       venceu,
    input  logic       perdeu,
    output logic       saida_serial,
    output logic       ocupado,
    output logic       pronto,
    output logic [3:0] db_estado
);

    localparam int              BAUD_W      = (CICLOS_POR_BIT > 1) ? $clog2(CICLOS_POR_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_ULTIMO = BAUD_W'(CICLOS_POR_BIT - 1);
    localparam logic [7:0]      CABECALHO   = 8'hA5;
    localparam logic [2:0]      ULTIMO_BYTE = 3'd4;

    typedef enum logic [3:0] {
        INICIAL = 4'h0,
        START   = 4'h1,
        DADOS   = 4'h2,
        STOP    = 4'h3,
        PROXIMO = 4'h4,
        FIM     = 4'h5
    } estado_t;

    estado_t           estado_q, estado_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [2:0]        byte_q, byte_d;
    logic [7:0]        b1_q, b1_d, b2_q, b2_d, b3_q, b3_d;
    logic              linha_q, linha_d;
    logic [7:0]        byte_atual;
    logic [2:0]        bit_prox;
    logic              fim_bit;
    logic              aceita;

    always_comb begin
        case (byte_q)
            3'd0:    byte_atual = CABECALHO;
            3'd1:    byte_atual = b1_q;
            3'd2:    byte_atual = b2_q;
            3'd3:    byte_atual = b3_q;
            default: byte_atual = b1_q ^ b2_q ^ b3_q;
        endcase
    end

    assign fim_bit  = (baud_q == BAUD_ULTIMO);
    assign bit_prox = bit_q + 3'd1;
    // FIM also accepts so that a held request yields frames separated only by the FIM cycle
    assign aceita   = enviar && ((estado_q == INICIAL) || (estado_q == FIM));

    always_comb begin
        estado_d = estado_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        byte_d   = byte_q;
        b1_d     = b1_q;
        b2_d     = b2_q;
        b3_d     = b3_q;
        linha_d  = linha_q;

        case (estado_q)
            INICIAL, FIM: begin
                estado_d = INICIAL;
                linha_d  = 1'b1;
                if (aceita) begin
                    estado_d = START;
                    baud_d   = '0;
                    bit_d    = '0;
                    byte_d   = '0;
                    b1_d     = {posicao_horizontal, posicao_vertical};
                    b2_d     = {obstaculos, modo, venceu, perdeu};
                    b3_d     = {5'b00000, vidas};
                    linha_d  = 1'b0;
                end
            end
            START: begin
                baud_d = baud_q + 1'b1;
                if (fim_bit) begin
                    estado_d = DADOS;
                    baud_d   = '0;
                    bit_d    = '0;
                    linha_d  = byte_atual[0];
                end
            end
            DADOS: begin
                baud_d = baud_q + 1'b1;
                if (fim_bit) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        estado_d = STOP;
                        linha_d  = 1'b1;
                    end else begin
                        bit_d   = bit_prox;
                        linha_d = byte_atual[bit_prox];
                    end
                end
            end
            STOP: begin
                baud_d = baud_q + 1'b1;
                if (fim_bit) begin
                    baud_d = '0;
                    if (byte_q == ULTIMO_BYTE) begin
                        estado_d = FIM;
                        linha_d  = 1'b1;
                    end else begin
                        // byte advance happens on this edge, no idle time between bytes
                        estado_d = START;
                        byte_d   = byte_q + 3'd1;
                        linha_d  = 1'b0;
                    end
                end
            end
            default: begin
                estado_d = INICIAL;
                baud_d   = '0;
                bit_d    = '0;
                byte_d   = '0;
                linha_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q <= INICIAL;
            baud_q   <= '0;
            bit_q    <= '0;
            byte_q   <= '0;
            b1_q     <= '0;
            b2_q     <= '0;
            b3_q     <= '0;
            linha_q  <= 1'b1;
        end else begin
            estado_q <= estado_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            byte_q   <= byte_d;
            b1_q     <= b1_d;
            b2_q     <= b2_d;
            b3_q     <= b3_d;
            linha_q  <= linha_d;
        end
    end

    assign saida_serial = linha_q;
    assign ocupado      = (estado_q == START) || (estado_q == DADOS) || (estado_q == STOP);
    assign pronto       = (estado_q == FIM);
    assign db_estado    = estado_q;

endmodule
`default_nettype wire
